// File: rtl/mult_hilo_ctrl.sv
// Multiplier sequencing stage: launches 16x16 multiplies, captures the product
// into HI/LO, serves mfhi/mflo/mthi/mtlo and stalls the pipeline while busy.
module mult_hilo_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mult_req,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               mfhi_req,
  input  logic               mflo_req,
  input  logic               mthi_req,
  input  logic               mtlo_req,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               St,
  output logic [WIDTH-1:0]   Multiplicador,
  output logic [WIDTH-1:0]   Multiplicando,
  input  logic [2*WIDTH-1:0] Produto,
  input  logic               Idle,
  input  logic               Done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               stall,
  output logic               timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             mt_any, mf_any, any_req;
  logic             acc_mult, acc_mt, acc_mfhi, acc_mflo;
  logic             cnt_last;

  assign mt_any   = mthi_req | mtlo_req;
  assign mf_any   = mfhi_req | mflo_req;
  assign any_req  = mult_req | mt_any | mf_any;
  assign busy     = (state != S_IDLE);
  assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));
  assign St       = (state == S_START) & Idle;

  // One request accepted per IDLE cycle: multiply, then moves-to, then moves-from.
  always_comb begin
    acc_mult   = 1'b0;
    acc_mt     = 1'b0;
    acc_mfhi   = 1'b0;
    acc_mflo   = 1'b0;
    stall      = 1'b0;
    state_next = state;
    case (state)
      S_IDLE: begin
        acc_mult = mult_req;
        acc_mt   = ~mult_req & mt_any;
        acc_mfhi = ~mult_req & ~mt_any & mfhi_req;
        acc_mflo = ~mult_req & ~mt_any & ~mfhi_req & mflo_req;
        stall    = (mult_req & (mt_any | mf_any)) |
                   (~mult_req & mt_any & mf_any) |
                   (~mult_req & ~mt_any & mfhi_req & mflo_req);
        if (mult_req) state_next = S_START;
      end
      S_START: begin
        stall = any_req;
        if (Idle) state_next = S_WAIT;
      end
      S_WAIT: begin
        stall = any_req;
        if (Done || cnt_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      Multiplicador <= '0;
      Multiplicando <= '0;
      hi            <= '0;
      lo            <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state    <= state_next;
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (acc_mult) begin
            Multiplicador <= op_a;
            Multiplicando <= op_b;
            timeout_err   <= 1'b0;
          end else if (acc_mt) begin
            if (mthi_req) hi <= wr_data;
            if (mtlo_req) lo <= wr_data;
          end else if (acc_mfhi || acc_mflo) begin
            rd_valid <= 1'b1;
            rd_data  <= acc_mfhi ? hi : lo;
          end
        end
        S_START: begin
          if (Idle) cnt <= '0;
        end
        S_WAIT: begin
          // Done beats a simultaneous timeout, so a late result is never flagged.
          if (Done) begin
            hi <= Produto[2*WIDTH-1:WIDTH];
            lo <= Produto[WIDTH-1:0];
          end else if (cnt_last) begin
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl; the bench itself plays the multiplier
// (Idle/Done/Produto) and checks against hand-computed values.
module tb_mult_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mult_req, mfhi_req, mflo_req, mthi_req, mtlo_req;
  logic [15:0] op_a, op_b, wr_data;
  logic        St;
  logic [15:0] Multiplicador, Multiplicando;
  logic [31:0] Produto;
  logic        Idle, Done;
  logic [15:0] hi, lo, rd_data;
  logic        rd_valid, busy, stall, timeout_err;

  int total = 0;
  int bad   = 0;
  int busy_miss;

  always #5 clk = ~clk;

  mult_hilo_ctrl #(.WIDTH(16), .TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .mult_req(mult_req), .op_a(op_a), .op_b(op_b),
    .mfhi_req(mfhi_req), .mflo_req(mflo_req),
    .mthi_req(mthi_req), .mtlo_req(mtlo_req), .wr_data(wr_data),
    .St(St), .Multiplicador(Multiplicador), .Multiplicando(Multiplicando),
    .Produto(Produto), .Idle(Idle), .Done(Done),
    .hi(hi), .lo(lo), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .stall(stall), .timeout_err(timeout_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; mult_req = 0; mfhi_req = 0; mflo_req = 0; mthi_req = 0; mtlo_req = 0;
    op_a = 0; op_b = 0; wr_data = 0; Produto = 0; Idle = 1'b1; Done = 1'b0;
    #12;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    checkOutput("rst_rdv", rd_valid, 0);
    checkOutput("rst_terr", timeout_err, 0);
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);

    // 0x1234 * 0x0010, Done 17 cycles after St
    op_a = 16'h1234; op_b = 16'h0010; mult_req = 1; #1;
    checkOutput("m1_stall_acc", stall, 0);
    applyStimulus(1);
    mult_req = 0; #1;
    checkOutput("m1_busy_start", busy, 1);
    checkOutput("m1_st_pulse", St, 1);
    checkOutput("m1_opa", Multiplicador, 16'h1234);
    checkOutput("m1_opb", Multiplicando, 16'h0010);
    busy_miss = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1);
      if (busy !== 1'b1 || St !== 1'b0) busy_miss++;
    end
    checkOutput("m1_wait_busy_nost", busy_miss, 0);
    Done = 1; Produto = 32'h0001_2340;
    applyStimulus(1);
    Done = 0; #1;
    checkOutput("m1_busy_done", busy, 0);
    checkOutput("m1_hi", hi, 16'h0001);
    checkOutput("m1_lo", lo, 16'h2340);

    // 0xFFFF * 0xFFFF then mfhi
    op_a = 16'hFFFF; op_b = 16'hFFFF; mult_req = 1;
    applyStimulus(1);
    mult_req = 0;
    applyStimulus(3);
    Done = 1; Produto = 32'hFFFE_0001;
    applyStimulus(1);
    Done = 0;
    checkOutput("m2_hi", hi, 16'hFFFE);
    checkOutput("m2_lo", lo, 16'h0001);
    mfhi_req = 1; #1;
    checkOutput("m2_mfhi_stall", stall, 0);
    applyStimulus(1);
    mfhi_req = 0; #1;
    checkOutput("m2_rdv", rd_valid, 1);
    checkOutput("m2_rdata", rd_data, 16'hFFFE);
    applyStimulus(1);
    checkOutput("m2_rdv_pulse", rd_valid, 0);

    // 3 * 5 with mflo held during the multiply
    op_a = 16'h0003; op_b = 16'h0005; mult_req = 1;
    applyStimulus(1);
    mult_req = 0; mflo_req = 1; #1;
    checkOutput("m3_stall_start", stall, 1);
    busy_miss = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      if (stall !== 1'b1 || rd_valid !== 1'b0) busy_miss++;
    end
    checkOutput("m3_stall_wait", busy_miss, 0);
    Done = 1; Produto = 32'h0000_000F; #1;
    checkOutput("m3_stall_done", stall, 1);
    applyStimulus(1);
    Done = 0; #1;
    checkOutput("m3_busy_clr", busy, 0);
    checkOutput("m3_stall_clr", stall, 0);
    applyStimulus(1);
    mflo_req = 0; #1;
    checkOutput("m3_rdv", rd_valid, 1);
    checkOutput("m3_rdata", rd_data, 16'h000F);

    // Timeout: Done never arrives
    op_a = 16'h0002; op_b = 16'h0002; mult_req = 1;
    applyStimulus(1);
    mult_req = 0;
    applyStimulus(1);
    busy_miss = 0;
    for (int i = 0; i < 63; i++) begin
      applyStimulus(1);
      if (busy !== 1'b1) busy_miss++;
    end
    checkOutput("to_busy_63", busy_miss, 0);
    checkOutput("to_err_early", timeout_err, 0);
    applyStimulus(1);
    checkOutput("to_busy_exit", busy, 0);
    checkOutput("to_err", timeout_err, 1);
    checkOutput("to_hi_keep", hi, 16'h0000);
    checkOutput("to_lo_keep", lo, 16'h000F);

    // Done while IDLE must be ignored
    Done = 1; Produto = 32'h1234_5678;
    applyStimulus(1);
    Done = 0;
    checkOutput("idle_done_hi", hi, 16'h0000);
    checkOutput("idle_done_busy", busy, 0);

    // Double write plus a losing read in the same cycle
    mthi_req = 1; mtlo_req = 1; mflo_req = 1; wr_data = 16'h5A5A; #1;
    checkOutput("mt_stall", stall, 1);
    applyStimulus(1);
    mthi_req = 0; mtlo_req = 0; mflo_req = 0;
    checkOutput("mt_hi", hi, 16'h5A5A);
    checkOutput("mt_lo", lo, 16'h5A5A);
    checkOutput("mt_rdv", rd_valid, 0);

    // mult + mthi + mflo together; multiplier not idle at first
    Idle = 0; op_a = 16'h0007; op_b = 16'h0009;
    mult_req = 1; mthi_req = 1; mflo_req = 1; wr_data = 16'hAAAA; #1;
    checkOutput("pri_stall", stall, 1);
    applyStimulus(1);
    mult_req = 0; mthi_req = 0; mflo_req = 0; #1;
    checkOutput("pri_hi_nowrite", hi, 16'h5A5A);
    checkOutput("pri_terr_clr", timeout_err, 0);
    checkOutput("pri_busy", busy, 1);
    checkOutput("start_noidle_st", St, 0);
    applyStimulus(1);
    checkOutput("start_hold_st", St, 0);
    checkOutput("start_hold_busy", busy, 1);
    Idle = 1; #1;
    checkOutput("start_idle_st", St, 1);
    applyStimulus(2);
    checkOutput("wait_st_low", St, 0);

    // Async reset between edges in WAIT
    #2 rst = 1'b0; #1;
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_st", St, 0);
    checkOutput("ar_opa", Multiplicador, 0);
    checkOutput("ar_opb", Multiplicando, 0);
    checkOutput("ar_hi", hi, 0);
    checkOutput("ar_lo", lo, 0);
    checkOutput("ar_rd", rd_data, 0);
    applyStimulus(1);
    rst = 1'b1;
    Done = 1; Produto = 32'hDEAD_BEEF;
    applyStimulus(1);
    Done = 0;
    checkOutput("post_done_busy", busy, 0);
    checkOutput("post_done_hi", hi, 0);
    checkOutput("post_done_lo", lo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
Sequencing stage directly upstream of the 16x16 multiplier, and also the consumer of its result. Accepts a multiply request from the datapath, registers the operands, and drives the multiplier's St/Multiplicador/Multiplicando. On Done it captures the 32-bit Produto into the HI/LO registers. It serves move-from/move-to HI/LO requests and stalls the pipeline while a multiply is in flight.

Parameters:
WIDTH, 16, operand width and HI/LO width; product is 2*WIDTH
TIMEOUT, 64, max cycles in WAIT before abort; minimum 2
CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
mult_req  in  1  multiply request, level, held by pipeline until not stalled
op_a  in  WIDTH  multiplier operand, sampled when mult_req accepted
op_b  in  WIDTH  multiplicand operand, sampled when mult_req accepted
mfhi_req  in  1  read HI request
mflo_req  in  1  read LO request
mthi_req  in  1  write HI request
mtlo_req  in  1  write LO request
wr_data  in  WIDTH  data for mthi/mtlo
St  out  1  start pulse to multiplier
Multiplicador  out  WIDTH  registered operand a to multiplier
Multiplicando  out  WIDTH  registered operand b to multiplier
Produto  in  2*WIDTH  product from multiplier
Idle  in  1  multiplier idle
Done  in  1  multiplier result valid, one-cycle pulse
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
rd_data  out  WIDTH  registered read data
rd_valid  out  1  one-cycle pulse, rd_data valid
busy  out  1  multiply in flight, i.e. state != IDLE
stall  out  1  combinational, the current request was not accepted this cycle
timeout_err  out  1  sticky, the last multiply aborted

Behaviour:
- Reset (rst=0, async): state=IDLE; St=0, Multiplicador=Multiplicando=0, hi=lo=0, rd_data=0, rd_valid=0, timeout_err=0, counter=0. Reset mid-operation abandons the multiply; hi and lo return to 0.
- FSM states: IDLE, START, WAIT.
- IDLE:
  - Accepts at most one request per cycle. Priority: mult_req > mthi/mtlo > mfhi/mflo. Every non-accepted asserted request raises stall.
  - mult_req accepted: latch op_a->Multiplicador, op_b->Multiplicando; clear timeout_err; go to START.
  - mthi/mtlo accepted: hi or lo <= wr_data next edge. If both are asserted, both registers are written in the same cycle.
  - mfhi/mflo accepted: rd_data <= hi or lo next edge; rd_valid=1 for one cycle. mfhi has priority over mflo; mflo stalls for one cycle.
  - Read of a register in the same cycle as its write is not possible, because the write wins priority.
- START:
  - Idle=1: St=1 for exactly this one cycle; go to WAIT; counter <= 0.
  - Idle=0: St=0; remain in START.
- WAIT:
  - St=0; counter increments each cycle.
  - Done=1: hi <= Produto[2W-1:W], lo <= Produto[W-1:0] at that edge; go to IDLE.
  - Counter reaches TIMEOUT-1 with Done=0: timeout_err <= 1; hi/lo unchanged; go to IDLE.
  - Done on the same cycle as the timeout: Done wins and no error is flagged.
- busy=1 in START and WAIT. stall = busy & (any request) | IDLE priority losers. A stalled request is not latched; the pipeline holds it.
- Latency: mult_req accepted at cycle 0 -> St at cycle 1 (Idle=1) -> hi/lo valid the cycle after Done.
  - mflo issued during WAIT stalls until IDLE, then returns the new lo.
- Done in IDLE or START is ignored.
- Produto is sampled only when Done=1 in WAIT.
- Unsigned multiply only; no sign handling in this block.
- Multiplicador/Multiplicando are held stable from acceptance until return to IDLE.

Test Plan:
- Reset, then op_a=0x1234, op_b=0x0010, mult_req=1 for one cycle; model Done 17 cycles after St -> St is a single pulse at cycle 1; busy=1 until the Done edge; hi=0x0001, lo=0x2340.
- op_a=op_b=0xFFFF -> hi=0xFFFE, lo=0x0001. Then mfhi_req=1 -> rd_valid next cycle with rd_data=0xFFFE.
- Start a multiply 0x0003*0x0005 and assert mflo_req during WAIT -> stall=1 every WAIT cycle. The first accepted read returns rd_data=0x000F; busy and stall deassert together.
- Hold Done=0 with TIMEOUT=64 -> exit to IDLE after 64 WAIT cycles; timeout_err=1; hi/lo keep their prior values. The next accepted mult_req clears timeout_err.
- In IDLE assert mult_req, mthi_req (wr_data=0xAAAA) and mflo_req in the same cycle -> multiply accepted; stall=1 for the others; hi is not written that cycle.
- Assert rst=0 asynchronously mid-WAIT, between clock edges -> all outputs are 0 immediately. A Done arriving after reset release is ignored; state stays IDLE.
